// File: rtl/btn_debounce.sv
// btn_debounce: N-channel push-button debouncer with a shared sample tick,
// press/release pulses and per-channel auto-repeat.
module btn_debounce #(
  parameter int N       = 3,
  parameter int DIV     = 1250000,
  parameter int STABLE  = 2,
  parameter int RPT_DLY = 20,
  parameter int RPT_PER = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] nBIN,
  input  logic [N-1:0] RPT_EN,
  output logic [N-1:0] BLVL,
  output logic [N-1:0] BOUT,
  output logic [N-1:0] BREL,
  output logic         TICK
);

  localparam int DW   = $clog2(DIV);
  localparam int SW   = $clog2(STABLE + 1);
  localparam int RMAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
  localparam int RW   = $clog2(RMAX + 1);

  logic [DW-1:0] r_div;
  logic          w_tick;
  logic [N-1:0]  r_sync1;
  logic [N-1:0]  r_sync2;
  logic [N-1:0]  w_s;

  assign w_tick = (r_div == DW'(DIV - 1));
  assign TICK   = w_tick;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

  // Synchronisers idle at the released (high) level.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= nBIN;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = ~r_sync2;

  for (genvar g = 0; g < N; g++) begin : g_ch
    logic [SW-1:0] r_stab;
    logic [RW-1:0] r_rpt;
    logic          r_lvl;
    logic          r_bout;
    logic          r_brel;
    logic [SW-1:0] w_inc;
    logic          w_diff;
    logic          w_acc;
    logic          w_press;
    logic          w_rel;
    logic          w_hit;

    assign w_inc   = r_stab + SW'(1);
    assign w_diff  = (w_s[g] != r_lvl);
    assign w_acc   = w_tick && w_diff && (w_inc == SW'(STABLE));
    assign w_press = w_acc && !r_lvl;
    assign w_rel   = w_acc && r_lvl;
    // A pending release holds off repeats so none fire after letting go.
    assign w_hit   = w_tick && !w_diff && r_lvl
                   && RPT_EN[g] && (r_rpt == RW'(1));

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        r_stab <= '0;
        r_rpt  <= '0;
        r_lvl  <= 1'b0;
        r_bout <= 1'b0;
        r_brel <= 1'b0;
      end else begin
        r_bout <= w_press || w_hit;
        r_brel <= w_rel;
        if (w_tick) begin
          if (!w_diff) begin
            r_stab <= '0;
          end else if (w_acc) begin
            r_stab <= '0;
            r_lvl  <= w_s[g];
          end else begin
            r_stab <= w_inc;
          end

          if (w_press) begin
            r_rpt <= RPT_EN[g] ? RW'(RPT_DLY) : '0;
          end else if (!r_lvl || !RPT_EN[g] || w_rel) begin
            r_rpt <= '0;
          end else if (w_hit) begin
            r_rpt <= RW'(RPT_PER);
          end else if (r_rpt > RW'(1)) begin
            r_rpt <= r_rpt - RW'(1);
          end
        end
      end
    end

    assign BLVL[g] = r_lvl;
    assign BOUT[g] = r_bout;
    assign BREL[g] = r_brel;
  end

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed scenarios for btn_debounce with
// N=3, DIV=4, STABLE=3, RPT_DLY=5, RPT_PER=2.
module tb_btn_debounce;

  logic       CLK;
  logic       RST;
  logic [2:0] nBIN;
  logic [2:0] RPT_EN;
  logic [2:0] BLVL;
  logic [2:0] BOUT;
  logic [2:0] BREL;
  logic       TICK;

  int tests;
  int fails;

  int bout_n[3];
  int bout_at[3][8];
  int brel_n[3];
  int brel_at[3];
  int lvl_at[3];

  btn_debounce #(
    .N(3), .DIV(4), .STABLE(3), .RPT_DLY(5), .RPT_PER(2)
  ) dut (
    .CLK(CLK), .RST(RST), .nBIN(nBIN), .RPT_EN(RPT_EN),
    .BLVL(BLVL), .BOUT(BOUT), .BREL(BREL), .TICK(TICK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Steps until the current cycle is a TICK cycle.
  task automatic align();
    for (int i = 0; i < 8; i++) begin
      if (TICK === 1'b1) break;
      step();
    end
    tests++;
    if (TICK !== 1'b1) begin
      fails++;
      $display("FAIL align: TICK=%b, required 1 within 8 cycles", TICK);
    end
  endtask

  // Records pulse cycles (1-based) over the next ncyc cycles.
  task automatic watch(input int ncyc);
    logic [2:0] lvl0;
    lvl0 = BLVL;
    for (int ch = 0; ch < 3; ch++) begin
      bout_n[ch]  = 0;
      brel_n[ch]  = 0;
      brel_at[ch] = 0;
      lvl_at[ch]  = 0;
      for (int k = 0; k < 8; k++) bout_at[ch][k] = 0;
    end
    for (int c = 1; c <= ncyc; c++) begin
      step();
      for (int ch = 0; ch < 3; ch++) begin
        if (BOUT[ch] === 1'b1) begin
          if (bout_n[ch] < 8) bout_at[ch][bout_n[ch]] = c;
          bout_n[ch]++;
        end
        if (BREL[ch] === 1'b1) begin
          if (brel_n[ch] == 0) brel_at[ch] = c;
          brel_n[ch]++;
        end
        if (lvl_at[ch] == 0 && BLVL[ch] !== lvl0[ch]) lvl_at[ch] = c;
      end
    end
  endtask

  task automatic test_reset();
    RST    = 1'b1;
    nBIN   = 3'b111;
    RPT_EN = 3'b000;
    repeat (3) step();
    tests++;
    if (BLVL !== 3'b000) begin
      fails++; $display("FAIL reset_blvl: got %b, required 000", BLVL);
    end
    tests++;
    if (BOUT !== 3'b000 || BREL !== 3'b000) begin
      fails++;
      $display("FAIL reset_pulses: BOUT=%b BREL=%b, required 000", BOUT, BREL);
    end
    tests++;
    if (TICK !== 1'b0) begin
      fails++; $display("FAIL reset_tick: got %b, required 0", TICK);
    end
    RST = 1'b0;
  endtask

  task automatic test_tick();
    int n;
    int first;
    int last;
    n = 0; first = 0; last = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (TICK === 1'b1) begin
        if (n == 0) first = c;
        last = c;
        n++;
      end
    end
    tests++;
    if (n != 3 || first != 3 || last != 11) begin
      fails++;
      $display("FAIL tick_period: n=%0d first=%0d last=%0d, required 3/3/11",
               n, first, last);
    end
  endtask

  task automatic test_press();
    align();
    nBIN[0] = 1'b0;
    watch(40);
    tests++;
    if (lvl_at[0] != 13) begin
      fails++; $display("FAIL press_lvl: rose at %0d, required 13", lvl_at[0]);
    end
    tests++;
    if (bout_n[0] != 1 || bout_at[0][0] != 13) begin
      fails++;
      $display("FAIL press_bout: n=%0d at %0d, required 1 at 13",
               bout_n[0], bout_at[0][0]);
    end
    tests++;
    if (brel_n[0] != 0 || bout_n[1] != 0 || bout_n[2] != 0) begin
      fails++;
      $display("FAIL press_others: brel0=%0d bout1=%0d bout2=%0d, required 0",
               brel_n[0], bout_n[1], bout_n[2]);
    end
  endtask

  task automatic test_release();
    align();
    nBIN[0] = 1'b1;
    watch(20);
    tests++;
    if (brel_n[0] != 1 || brel_at[0] != 13 || lvl_at[0] != 13) begin
      fails++;
      $display("FAIL release_brel: n=%0d at %0d lvl at %0d, required 1/13/13",
               brel_n[0], brel_at[0], lvl_at[0]);
    end
    tests++;
    if (bout_n[0] != 0) begin
      fails++; $display("FAIL release_bout: n=%0d, required 0", bout_n[0]);
    end
  endtask

  task automatic test_glitch();
    int acts;
    align();
    nBIN[1] = 1'b0;
    watch(8);
    acts = bout_n[1] + brel_n[1] + lvl_at[1];
    nBIN[1] = 1'b1;
    watch(30);
    acts = acts + bout_n[1] + brel_n[1] + lvl_at[1];
    tests++;
    if (acts != 0 || BLVL[1] !== 1'b0) begin
      fails++;
      $display("FAIL glitch: activity=%0d BLVL1=%b, required 0/0", acts, BLVL[1]);
    end
  endtask

  task automatic test_repeat();
    RPT_EN[0] = 1'b1;
    align();
    nBIN[0] = 1'b0;
    watch(50);
    tests++;
    if (bout_n[0] != 4) begin
      fails++; $display("FAIL repeat_count: got %0d, required 4", bout_n[0]);
    end
    tests++;
    if (bout_at[0][0] != 13 || bout_at[0][1] != 33 ||
        bout_at[0][2] != 41 || bout_at[0][3] != 49) begin
      fails++;
      $display("FAIL repeat_times: %0d %0d %0d %0d, required 13 33 41 49",
               bout_at[0][0], bout_at[0][1], bout_at[0][2], bout_at[0][3]);
    end
  endtask

  task automatic test_repeat_release();
    align();
    nBIN[0] = 1'b1;
    watch(30);
    tests++;
    if (brel_n[0] != 1 || brel_at[0] != 13) begin
      fails++;
      $display("FAIL rpt_rel_brel: n=%0d at %0d, required 1 at 13",
               brel_n[0], brel_at[0]);
    end
    tests++;
    if (bout_n[0] != 0 || BLVL[0] !== 1'b0) begin
      fails++;
      $display("FAIL rpt_rel_bout: n=%0d BLVL0=%b, required 0/0",
               bout_n[0], BLVL[0]);
    end
    RPT_EN[0] = 1'b0;
  endtask

  task automatic test_simul();
    align();
    nBIN[2:1] = 2'b00;
    watch(20);
    tests++;
    if (bout_n[1] != 1 || bout_n[2] != 1 ||
        bout_at[1][0] != 13 || bout_at[2][0] != 13) begin
      fails++;
      $display("FAIL simul_press: n1=%0d@%0d n2=%0d@%0d, required 1@13 each",
               bout_n[1], bout_at[1][0], bout_n[2], bout_at[2][0]);
    end
    tests++;
    if (bout_at[1][0] != bout_at[2][0]) begin
      fails++;
      $display("FAIL simul_same: ch1@%0d ch2@%0d, required equal",
               bout_at[1][0], bout_at[2][0]);
    end
    align();
    nBIN[2:1] = 2'b11;
    watch(20);
    tests++;
    if (brel_at[1] != 13 || brel_at[2] != 13) begin
      fails++;
      $display("FAIL simul_release: ch1@%0d ch2@%0d, required 13/13",
               brel_at[1], brel_at[2]);
    end
  endtask

  task automatic test_reset_midhold();
    nBIN[0] = 1'b0;
    align();
    watch(20);
    tests++;
    if (BLVL[0] !== 1'b1) begin
      fails++; $display("FAIL midhold_pre: BLVL0=%b, required 1", BLVL[0]);
    end
    step();
    #2;
    RST = 1'b1;
    #1;
    tests++;
    if (BLVL !== 3'b000 || BOUT !== 3'b000 ||
        BREL !== 3'b000 || TICK !== 1'b0) begin
      fails++;
      $display("FAIL midhold_async: BLVL=%b BOUT=%b BREL=%b TICK=%b, required 0",
               BLVL, BOUT, BREL, TICK);
    end
    step();
    step();
    RST = 1'b0;
    watch(30);
    tests++;
    if (bout_n[0] != 1 || bout_at[0][0] != 12 || lvl_at[0] != 12) begin
      fails++;
      $display("FAIL midhold_redetect: n=%0d at %0d lvl at %0d, required 1/12/12",
               bout_n[0], bout_at[0][0], lvl_at[0]);
    end
    tests++;
    if (brel_n[0] != 0) begin
      fails++; $display("FAIL midhold_brel: n=%0d, required 0", brel_n[0]);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_tick();
    test_press();
    test_release();
    test_glitch();
    test_repeat();
    test_repeat_release();
    test_simul();
    test_reset_midhold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter N, default 3: number of independent button channels, N >= 1.
REQ-002 Parameter DIV, default 1250000: sample-tick period in CLK cycles (40 Hz at 50 MHz), DIV >= 2.
REQ-003 Parameter STABLE, default 2: consecutive differing ticks required to accept a new level, STABLE >= 1.
REQ-004 Parameter RPT_DLY, default 20: ticks from accepted press to first auto-repeat pulse, RPT_DLY >= 1.
REQ-005 Parameter RPT_PER, default 4: ticks between later auto-repeat pulses, RPT_PER >= 1.
REQ-006 CLK  input  1  single clock; all state on rising edge.
REQ-007 RST  input  1  reset, asynchronous, active-high.
REQ-008 nBIN  input  N  raw button inputs, active-low (0 = pressed), asynchronous to CLK.
REQ-009 RPT_EN  input  N  per-channel auto-repeat enable, synchronous to CLK.
REQ-010 BLVL  output  N  debounced level, 1 = pressed.
REQ-011 BOUT  output  N  one-cycle pulse per accepted press and per auto-repeat event.
REQ-012 BREL  output  N  one-cycle pulse per accepted release.
REQ-013 TICK  output  1  one-cycle sample-tick strobe.

Function
REQ-014 Tick divider SHALL count 0..DIV-1 and wrap; TICK SHALL be 1 exactly in the cycle the count equals DIV-1; counter width SHALL be $clog2(DIV).
REQ-015 Each nBIN bit SHALL pass a two-flop synchroniser clocked every cycle; sampled value s = inverted synchroniser output.
REQ-016 Per channel, on a TICK cycle: if s == BLVL, stability counter SHALL clear to 0; otherwise it SHALL increment, and when the incremented value equals STABLE, BLVL SHALL take s and the counter SHALL clear.
REQ-017 Non-TICK cycles SHALL leave BLVL, stability and repeat counters unchanged.
REQ-018 BOUT SHALL be 1 for exactly the one cycle following the edge at which BLVL goes 0->1 (registered, latency 1 cycle after the accepting TICK edge).
REQ-019 BREL SHALL be 1 for exactly the one cycle following the edge at which BLVL goes 1->0.
REQ-020 Repeat counter per channel, width $clog2(max(RPT_DLY,RPT_PER)+1): loaded with RPT_DLY on press acceptance; on each later TICK with BLVL=1 and RPT_EN=1 it SHALL decrement; on a TICK where it equals 1, BOUT SHALL pulse (same 1-cycle timing as REQ-018) and counter SHALL reload RPT_PER.
REQ-021 RPT_EN=0 or BLVL=0 SHALL clear the repeat counter to 0; re-asserting RPT_EN during a hold SHALL NOT restart repeats until the next accepted press.
REQ-022 Press acceptance and repeat decrement cannot coincide; acceptance TICK SHALL only load, never pulse twice.
REQ-023 Channels SHALL be fully independent; simultaneous events on several channels SHALL produce pulses in the same cycle.
REQ-024 Input glitches shorter than STABLE ticks SHALL produce no BLVL, BOUT or BREL activity.

Reset
REQ-025 RST=1 SHALL immediately force BLVL, BOUT, BREL, TICK, divider, stability and repeat counters to 0, and synchroniser flops to 1 (released).
REQ-026 After RST release with a button held, the press SHALL be re-detected normally (BOUT after STABLE ticks); no pulse SHALL occur from reset itself.

Verification (N=3, DIV=4, STABLE=3, RPT_DLY=5, RPT_PER=2)
REQ-027 nBIN[0] 1->0 held, RPT_EN=0 -> BLVL[0]=1 at 3rd TICK after synchroniser sees 0, BOUT[0] single 1-cycle pulse, no further pulses.
REQ-028 nBIN[1] low for 2 ticks then high -> BLVL[1], BOUT[1], BREL[1] stay 0.
REQ-029 nBIN[0] held, RPT_EN[0]=1 -> BOUT[0] pulses at acceptance tick T, then T+5, T+7, T+9 ticks.
REQ-030 Release after REQ-029 -> BREL[0] 1-cycle pulse 3 ticks after release, no further BOUT[0].
REQ-031 nBIN[1] and nBIN[2] fall same cycle -> BOUT[1] and BOUT[2] pulse in the same cycle.
REQ-032 RST pulsed mid-hold between TICKs -> all outputs 0 asynchronously; after release with button still held, BOUT pulses once at 3rd TICK.
